// File: rtl/vec_reduce.sv
// vec_reduce: streams n signed elements out of one or two single-port SRAMs
// and produces a sum, a dot product, or an in-place prefix sum written to b.
// Control follows the ap_ctrl_hs start/idle/done/ready handshake.
module vec_reduce #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32,
    parameter int ACC_W  = 32,
    parameter int RD_LAT = 1
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_idle,
    output logic              ap_done,
    output logic              ap_ready,
    input  logic [CNT_W-1:0]  n,
    input  logic [1:0]        mode,
    output logic [ADDR_W-1:0] a_address0,
    output logic              a_ce0,
    input  logic [DATA_W-1:0] a_q0,
    output logic [ADDR_W-1:0] b_address0,
    output logic              b_ce0,
    output logic              b_we0,
    output logic [DATA_W-1:0] b_d0,
    input  logic [DATA_W-1:0] b_q0,
    output logic [ACC_W-1:0]  ap_return
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] M_SUM = 2'd0;
    localparam logic [1:0] M_DOT = 2'd1;
    localparam logic [1:0] M_PFX = 2'd2;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic [CNT_W-1:0]   i_q, i_d;
    logic [1:0]         mode_q, mode_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   ret_q, ret_d;
    logic [RD_LAT-1:0]  vld_q, vld_d;
    logic [CNT_W-1:0]   idx_q [RD_LAT];
    logic [CNT_W-1:0]   idx_d [RD_LAT];

    logic               issue;
    logic               consume;
    logic               last_issue;
    logic               pipe_rest;
    logic [ACC_W-1:0]   term;
    logic [ACC_W-1:0]   acc_sum;

    genvar gi;

    assign issue      = (state_q == S_RUN);
    assign consume    = vld_q[RD_LAT-1];
    assign last_issue = (i_q == n_q - CNT_W'(1));

    // Read-valid pipeline: each stage hands {valid, index} to the next one
    for (gi = 0; gi < RD_LAT; gi++) begin : g_pipe
        if (gi == 0) begin : g_head
            assign vld_d[gi] = issue;
            assign idx_d[gi] = i_q;
        end else begin : g_tail
            assign vld_d[gi] = vld_q[gi-1];
            assign idx_d[gi] = idx_q[gi-1];
        end
    end

    // Elements still in flight behind the one emerging this cycle
    if (RD_LAT > 1) begin : g_rest
        assign pipe_rest = |vld_q[RD_LAT-2:0];
    end else begin : g_norest
        assign pipe_rest = 1'b0;
    end

    // Accumulate term: sign-extending both operands to ACC_W before the multiply
    // gives the low ACC_W bits of the full 2*DATA_W product when ACC_W is narrower,
    // and the exact sign-extended product when ACC_W is wider.
    always_comb begin
        if (mode_q == M_DOT) begin
            term = ACC_W'($signed(a_q0)) * ACC_W'($signed(b_q0));
        end else begin
            term = ACC_W'($signed(a_q0));
        end
        acc_sum = acc_q + term;
    end

    // Next-state logic for the control FSM, counters and accumulator
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        mode_d  = mode_q;
        i_d     = i_q;
        acc_d   = acc_q;
        ret_d   = ret_q;
        if (consume) begin
            acc_d = acc_sum;
        end
        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    n_d     = n;
                    mode_d  = (mode == 2'd3) ? M_SUM : mode;
                    i_d     = '0;
                    acc_d   = '0;
                    state_d = (n == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                i_d = i_q + CNT_W'(1);
                if (last_issue) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!pipe_rest) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Result register captures the final sum on the edge that enters DONE
        if (state_d == S_DONE) begin
            ret_d = acc_d;
        end
    end

    // SRAM port drive; gated by reset so an aborted run stops touching memory at once
    always_comb begin
        a_ce0      = 1'b0;
        a_address0 = '0;
        b_ce0      = 1'b0;
        b_we0      = 1'b0;
        b_address0 = '0;
        b_d0       = '0;
        if (ap_rst_n) begin
            if (issue) begin
                a_ce0      = 1'b1;
                a_address0 = ADDR_W'(i_q);
                if (mode_q == M_DOT) begin
                    b_ce0      = 1'b1;
                    b_address0 = ADDR_W'(i_q);
                end
            end
            if (consume && (mode_q == M_PFX)) begin
                b_ce0      = 1'b1;
                b_we0      = 1'b1;
                b_address0 = ADDR_W'(idx_q[RD_LAT-1]);
                b_d0       = acc_sum[DATA_W-1:0];
            end
        end
    end

    // State, counters, accumulator, result and read-valid pipeline registers
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            i_q     <= '0;
            mode_q  <= M_SUM;
            acc_q   <= '0;
            ret_q   <= '0;
            vld_q   <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                idx_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            i_q     <= i_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            ret_q   <= ret_d;
            vld_q   <= vld_d;
            idx_q   <= idx_d;
        end
    end

    assign ap_idle   = (state_q == S_IDLE);
    assign ap_done   = (state_q == S_DONE);
    assign ap_ready  = ap_done;
    assign ap_return = ret_q;

endmodule

// File: tb/tb_vec_reduce.sv
// Bench for vec_reduce: two instances (read latency 1 and 3) each with its own
// SRAM models, checked against a plain arithmetic reference model.
module tb_vec_reduce;

    localparam int NU = 2;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] ret;
        int          done_c;
        int          width;
        int          ce_cnt;
        int          we_cnt;
        int          bce_cnt;
        bit          addr_ok;
        bit          rdy_ok;
    } run_t;

    logic        clk = 1'b0;
    logic        rst_n   [NU];
    logic        start_s [NU];
    logic [31:0] n_s     [NU];
    logic [1:0]  mode_s  [NU];
    logic        idle_o  [NU];
    logic        done_o  [NU];
    logic        ready_o [NU];
    logic [31:0] a_addr  [NU];
    logic [31:0] b_addr  [NU];
    logic [31:0] b_d     [NU];
    logic [31:0] a_q     [NU];
    logic [31:0] b_q     [NU];
    logic [31:0] ret_o   [NU];
    logic        a_ce    [NU];
    logic        b_ce    [NU];
    logic        b_we    [NU];
    logic [31:0] a_init  [NU][64];
    logic [31:0] b_init  [NU][64];
    logic        load    [NU];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NU; gi++) begin : g_unit
        localparam int LAT = (gi == 0) ? 1 : 3;
        logic [31:0] b_mem  [64];
        logic [31:0] a_pipe [LAT];
        logic [31:0] b_pipe [LAT];

        vec_reduce #(.RD_LAT(LAT)) u_dut (
            .ap_clk     (clk),
            .ap_rst_n   (rst_n[gi]),
            .ap_start   (start_s[gi]),
            .ap_idle    (idle_o[gi]),
            .ap_done    (done_o[gi]),
            .ap_ready   (ready_o[gi]),
            .n          (n_s[gi]),
            .mode       (mode_s[gi]),
            .a_address0 (a_addr[gi]),
            .a_ce0      (a_ce[gi]),
            .a_q0       (a_q[gi]),
            .b_address0 (b_addr[gi]),
            .b_ce0      (b_ce[gi]),
            .b_we0      (b_we[gi]),
            .b_d0       (b_d[gi]),
            .b_q0       (b_q[gi]),
            .ap_return  (ret_o[gi])
        );

        // SRAM models with LAT-cycle read latency; junk when not enabled
        always @(posedge clk) begin
            if (load[gi]) begin
                for (int k = 0; k < 64; k++) b_mem[k] <= b_init[gi][k];
            end else if (b_ce[gi] && b_we[gi]) begin
                b_mem[b_addr[gi][5:0]] <= b_d[gi];
            end
            a_pipe[0] <= a_ce[gi] ? a_init[gi][a_addr[gi][5:0]] : JUNK;
            b_pipe[0] <= (b_ce[gi] && !b_we[gi]) ? b_mem[b_addr[gi][5:0]] : JUNK;
            for (int k = 1; k < LAT; k++) begin
                a_pipe[k] <= a_pipe[k-1];
                b_pipe[k] <= b_pipe[k-1];
            end
        end
        assign a_q[gi] = a_pipe[LAT-1];
        assign b_q[gi] = b_pipe[LAT-1];
    end

    function automatic int lat(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] get_b(input int u, input int k);
        return (u == 0) ? g_unit[0].b_mem[k] : g_unit[1].b_mem[k];
    endfunction

    // Reference: plain 32-bit wrapping sum of a[k] or a[k]*b[k]
    function automatic logic [31:0] model_result(input int u, input int nn, input int md);
        logic [31:0] acc;
        acc = '0;
        for (int k = 0; k < nn; k++) begin
            if (md == 1) acc = acc + a_init[u][k] * b_init[u][k];
            else         acc = acc + a_init[u][k];
        end
        return acc;
    endfunction

    task automatic load_mem(input int u);
        load[u] = 1'b1;
        @(posedge clk); #1;
        load[u] = 1'b0;
    endtask

    // Start one run (DUT idle, called just after a rising edge) and watch it to completion
    task automatic do_run(input int u, input int nn, input int md, output run_t r);
        r.ret = '0; r.done_c = -1; r.width = 0; r.ce_cnt = 0; r.we_cnt = 0;
        r.bce_cnt = 0; r.addr_ok = 1'b1; r.rdy_ok = 1'b1;
        n_s[u] = 32'(nn); mode_s[u] = 2'(md); start_s[u] = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (done_o[u]) begin
                if (r.done_c < 0) r.done_c = c;
                r.width++;
            end
            if (ready_o[u] !== done_o[u]) r.rdy_ok = 1'b0;
            if (a_ce[u]) begin
                if (a_addr[u] !== 32'(r.ce_cnt)) r.addr_ok = 1'b0;
                r.ce_cnt++;
            end
            if (b_ce[u] && b_we[u]) r.we_cnt++;
            if (b_ce[u] && !b_we[u]) r.bce_cnt++;
            @(posedge clk); #1;
            start_s[u] = 1'b0;
            if (r.done_c >= 0 && c >= r.done_c + 2) break;
        end
        r.ret = ret_o[u];
        $display("run u=%0d n=%0d mode=%0d ret=%08h done_cycle=%0d ce=%0d we=%0d",
                 u, nn, md, r.ret, r.done_c, r.ce_cnt, r.we_cnt);
    endtask

    task automatic test_reset();
        for (int u = 0; u < NU; u++) begin
            checks += 6;
            if (idle_o[u] !== 1'b1) begin errors++; $display("FAIL reset_idle u=%0d: got %b expected 1", u, idle_o[u]); end
            if (done_o[u] !== 1'b0 || ready_o[u] !== 1'b0) begin errors++; $display("FAIL reset_done u=%0d: got %b/%b expected 0/0", u, done_o[u], ready_o[u]); end
            if (ret_o[u] !== 32'h0) begin errors++; $display("FAIL reset_ret u=%0d: got %08h expected 0", u, ret_o[u]); end
            if (a_ce[u] !== 1'b0 || b_ce[u] !== 1'b0 || b_we[u] !== 1'b0) begin errors++; $display("FAIL reset_ce u=%0d: got %b%b%b expected 000", u, a_ce[u], b_ce[u], b_we[u]); end
            if (a_addr[u] !== 32'h0 || b_addr[u] !== 32'h0) begin errors++; $display("FAIL reset_addr u=%0d: got %08h/%08h expected 0/0", u, a_addr[u], b_addr[u]); end
            if (b_d[u] !== 32'h0) begin errors++; $display("FAIL reset_bd u=%0d: got %08h expected 0", u, b_d[u]); end
        end
    endtask

    task automatic test_sum(input int u);
        run_t r;
        for (int k = 0; k < 10; k++) a_init[u][k] = 32'(k + 1);
        load_mem(u);
        do_run(u, 10, 0, r);
        checks += 5;
        if (r.ret !== 32'd55) begin errors++; $display("FAIL sum_ret u=%0d: got %0d expected 55", u, r.ret); end
        if (r.done_c != 10 + lat(u) + 1) begin errors++; $display("FAIL sum_done_cycle u=%0d: got %0d expected %0d", u, r.done_c, 10 + lat(u) + 1); end
        if (r.width != 1) begin errors++; $display("FAIL sum_done_width u=%0d: got %0d expected 1", u, r.width); end
        if (r.ce_cnt != 10 || !r.addr_ok) begin errors++; $display("FAIL sum_a_ce u=%0d: got %0d cycles addr_ok=%0d expected 10 addr_ok=1", u, r.ce_cnt, r.addr_ok); end
        if (!r.rdy_ok) begin errors++; $display("FAIL sum_ready u=%0d: got ready!=done expected ready==done", u); end
    endtask

    task automatic test_dot(input int u);
        run_t r;
        for (int k = 0; k < 64; k++) b_init[u][k] = 32'd2;
        for (int k = 0; k < 10; k++) a_init[u][k] = 32'(k + 1);
        load_mem(u);
        do_run(u, 10, 1, r);
        checks += 4;
        if (r.ret !== 32'd110) begin errors++; $display("FAIL dot_ret u=%0d: got %0d expected 110", u, r.ret); end
        if (r.we_cnt != 0) begin errors++; $display("FAIL dot_no_write u=%0d: got %0d writes expected 0", u, r.we_cnt); end
        if (r.bce_cnt != 10) begin errors++; $display("FAIL dot_b_reads u=%0d: got %0d expected 10", u, r.bce_cnt); end
        if (r.done_c != 10 + lat(u) + 1) begin errors++; $display("FAIL dot_done_cycle u=%0d: got %0d expected %0d", u, r.done_c, 10 + lat(u) + 1); end
    endtask

    task automatic test_prefix(input int u);
        run_t r;
        logic [31:0] psum;
        for (int k = 0; k < 64; k++) b_init[u][k] = 32'hA5A5_0000 + 32'(k);
        for (int k = 0; k < 10; k++) a_init[u][k] = 32'(k + 1);
        load_mem(u);
        do_run(u, 10, 2, r);
        checks += 4;
        if (r.ret !== 32'd55) begin errors++; $display("FAIL pfx_ret u=%0d: got %0d expected 55", u, r.ret); end
        if (r.we_cnt != 10 || r.bce_cnt != 0) begin errors++; $display("FAIL pfx_port u=%0d: got we=%0d rd=%0d expected we=10 rd=0", u, r.we_cnt, r.bce_cnt); end
        if (get_b(u, 10) !== 32'hA5A5_000A) begin errors++; $display("FAIL pfx_b_beyond u=%0d: got %08h expected a5a5000a", u, get_b(u, 10)); end
        if (r.done_c != 10 + lat(u) + 1) begin errors++; $display("FAIL pfx_done_cycle u=%0d: got %0d expected %0d", u, r.done_c, 10 + lat(u) + 1); end
        psum = '0;
        for (int k = 0; k < 10; k++) begin
            psum = psum + a_init[u][k];
            checks++;
            if (get_b(u, k) !== psum) begin errors++; $display("FAIL pfx_b u=%0d k=%0d: got %0d expected %0d", u, k, get_b(u, k), psum); end
        end
    endtask

    task automatic test_zero(input int u);
        run_t r;
        do_run(u, 0, 0, r);
        checks += 3;
        if (r.done_c != 1 || r.width != 1) begin errors++; $display("FAIL zero_done u=%0d: got cycle %0d width %0d expected cycle 1 width 1", u, r.done_c, r.width); end
        if (r.ret !== 32'h0) begin errors++; $display("FAIL zero_ret u=%0d: got %08h expected 0", u, r.ret); end
        if (r.ce_cnt != 0 || r.bce_cnt != 0 || r.we_cnt != 0) begin errors++; $display("FAIL zero_ce u=%0d: got a=%0d b=%0d w=%0d expected 0/0/0", u, r.ce_cnt, r.bce_cnt, r.we_cnt); end
    endtask

    task automatic test_wrap();
        run_t r;
        a_init[0][0] = 32'hFFFF_FFFD;
        a_init[0][1] = 32'd5;
        do_run(0, 2, 0, r);
        checks++;
        if (r.ret !== 32'd2) begin errors++; $display("FAIL wrap_signed: got %08h expected 00000002", r.ret); end
        a_init[0][0] = 32'h7FFF_FFFF;
        a_init[0][1] = 32'h7FFF_FFFF;
        do_run(0, 2, 0, r);
        checks++;
        if (r.ret !== 32'hFFFF_FFFE) begin errors++; $display("FAIL wrap_overflow: got %08h expected fffffffe", r.ret); end
    endtask

    task automatic test_abort(input int u);
        run_t r;
        int   dn;
        int   ce;
        for (int k = 0; k < 10; k++) a_init[u][k] = 32'(k + 1);
        n_s[u] = 32'd10; mode_s[u] = 2'd0; start_s[u] = 1'b1;
        @(posedge clk); #1;
        start_s[u] = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst_n[u] = 1'b0;
        @(posedge clk); #1;
        rst_n[u] = 1'b1;
        checks += 3;
        if (idle_o[u] !== 1'b1) begin errors++; $display("FAIL abort_idle u=%0d: got %b expected 1", u, idle_o[u]); end
        if (a_ce[u] !== 1'b0 || b_ce[u] !== 1'b0) begin errors++; $display("FAIL abort_ce u=%0d: got %b%b expected 00", u, a_ce[u], b_ce[u]); end
        if (ret_o[u] !== 32'h0) begin errors++; $display("FAIL abort_ret u=%0d: got %08h expected 0", u, ret_o[u]); end
        dn = 0; ce = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done_o[u]) dn++;
            if (a_ce[u]) ce++;
        end
        @(posedge clk); #1;
        checks++;
        if (dn != 0 || ce != 0) begin errors++; $display("FAIL abort_quiet u=%0d: got done=%0d ce=%0d expected 0/0", u, dn, ce); end
        do_run(u, 10, 0, r);
        checks++;
        if (r.ret !== 32'd55 || r.done_c != 10 + lat(u) + 1) begin errors++; $display("FAIL abort_rerun u=%0d: got ret %0d cycle %0d expected 55 cycle %0d", u, r.ret, r.done_c, 10 + lat(u) + 1); end
    endtask

    task automatic test_back_to_back(input int u);
        int d1, d2, pulses, exp1, exp2;
        logic [31:0] ret_mid;
        for (int k = 0; k < 10; k++) a_init[u][k] = 32'(k + 1);
        d1 = -1; d2 = -1; pulses = 0; ret_mid = 'x;
        exp1 = 4 + lat(u) + 1;
        exp2 = exp1 + 1 + 3 + lat(u) + 1;
        n_s[u] = 32'd4; mode_s[u] = 2'd0; start_s[u] = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (done_o[u]) begin
                pulses++;
                if (d1 < 0) d1 = c;
                else if (d2 < 0) d2 = c;
            end
            if (d1 >= 0 && c == d1 + 1) ret_mid = ret_o[u];
            @(posedge clk); #1;
            if (c == 1) n_s[u] = 32'd3;
            if (d2 >= 0) start_s[u] = 1'b0;
            if (d2 >= 0 && c >= d2 + 4) break;
        end
        start_s[u] = 1'b0;
        $display("b2b u=%0d done1=%0d done2=%0d ret1=%0d ret2=%0d", u, d1, d2, ret_mid, ret_o[u]);
        checks += 4;
        if (d1 != exp1 || d2 != exp2) begin errors++; $display("FAIL b2b_cycles u=%0d: got %0d,%0d expected %0d,%0d", u, d1, d2, exp1, exp2); end
        if (pulses != 2) begin errors++; $display("FAIL b2b_pulses u=%0d: got %0d expected 2", u, pulses); end
        if (ret_mid !== 32'd10) begin errors++; $display("FAIL b2b_ret1 u=%0d: got %0d expected 10", u, ret_mid); end
        if (ret_o[u] !== 32'd6 || idle_o[u] !== 1'b1) begin errors++; $display("FAIL b2b_ret2 u=%0d: got %0d idle=%b expected 6 idle=1", u, ret_o[u], idle_o[u]); end
    endtask

    task automatic test_random(input int u);
        run_t r;
        int nn, md, bad, first, exp_done;
        logic [31:0] psum, exp_v, exp_ret;
        for (int t = 0; t < 6; t++) begin
            nn = $urandom_range(0, 24);
            md = $urandom_range(0, 3);
            for (int k = 0; k < 64; k++) begin
                a_init[u][k] = $urandom();
                b_init[u][k] = $urandom();
            end
            load_mem(u);
            exp_ret  = model_result(u, nn, md);
            exp_done = (nn == 0) ? 1 : nn + lat(u) + 1;
            do_run(u, nn, md, r);
            checks += 4;
            if (r.ret !== exp_ret) begin errors++; $display("FAIL rand_ret u=%0d n=%0d mode=%0d: got %08h expected %08h", u, nn, md, r.ret, exp_ret); end
            if (r.done_c != exp_done || r.width != 1) begin errors++; $display("FAIL rand_done u=%0d n=%0d: got cycle %0d width %0d expected %0d width 1", u, nn, r.done_c, r.width, exp_done); end
            if (r.ce_cnt != nn || r.bce_cnt != ((md == 1) ? nn : 0) || r.we_cnt != ((md == 2) ? nn : 0))
                begin errors++; $display("FAIL rand_ports u=%0d n=%0d mode=%0d: got a=%0d br=%0d bw=%0d", u, nn, md, r.ce_cnt, r.bce_cnt, r.we_cnt); end
            bad = 0; first = -1; psum = '0;
            for (int k = 0; k < 64; k++) begin
                if (md == 2 && k < nn) begin
                    psum  = psum + a_init[u][k];
                    exp_v = psum;
                end else begin
                    exp_v = b_init[u][k];
                end
                if (get_b(u, k) !== exp_v) begin
                    bad++;
                    if (first < 0) first = k;
                end
            end
            if (bad != 0) begin errors++; $display("FAIL rand_bmem u=%0d n=%0d mode=%0d: got %0d wrong words (first k=%0d) expected 0", u, nn, md, bad, first); end
        end
    endtask

    initial begin
        for (int u = 0; u < NU; u++) begin
            rst_n[u] = 1'b0; start_s[u] = 1'b0; n_s[u] = '0; mode_s[u] = '0; load[u] = 1'b0;
            for (int k = 0; k < 64; k++) begin
                a_init[u][k] = '0;
                b_init[u][k] = '0;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        for (int u = 0; u < NU; u++) rst_n[u] = 1'b1;
        @(posedge clk); #1;
        for (int u = 0; u < NU; u++) begin
            test_sum(u);
            test_dot(u);
            test_prefix(u);
            test_zero(u);
        end
        test_wrap();
        for (int u = 0; u < NU; u++) begin
            test_abort(u);
            test_back_to_back(u);
            test_random(u);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vec_reduce.md
Name: vec_reduce

Overview:
- Parametrised successor to the HLS-style single-array summation kernel.
- Streams n elements out of one or two single-port SRAMs and produces one of three results: a sum, a dot product, or an in-place prefix-sum write-back.
- Uses the ap_ctrl_hs start/idle/done/ready handshake.
- Sits between the control FSM and the array SRAMs, alongside other HLS kernels.

Parameters:
- DATA_W, 32: element width. Elements are signed two's complement.
- ADDR_W, 32: SRAM address width.
- CNT_W, 32: width of the element count n.
- ACC_W, 32: accumulator and ap_return width. Must satisfy ACC_W >= DATA_W.
- RD_LAT, 1: SRAM read latency in cycles, ≥1. q0 is valid RD_LAT cycles after the cycle in which ce0 is high.

Ports:
- ap_clk  in  1  clock, rising edge.
- ap_rst_n  in  1  synchronous reset, active-low.
- ap_start  in  1  level start request.
- ap_idle  out  1  high in IDLE.
- ap_done  out  1  one-cycle pulse, result valid.
- ap_ready  out  1  equal to ap_done. New inputs are accepted next cycle.
- n  in  CNT_W  element count, unsigned. Sampled at start.
- mode  in  2  operation select. Sampled at start: 0 = sum(a), 1 = dot(a,b), 2 = prefix(a)→b, 3 = treated as 0.
- a_address0  out  ADDR_W  read address for a.
- a_ce0  out  1  read enable for a.
- a_q0  in  DATA_W  read data from a.
- b_address0  out  ADDR_W  address for b. Read address in mode 1, write address in mode 2.
- b_ce0  out  1  enable for b.
- b_we0  out  1  write enable for b (mode 2 only).
- b_d0  out  DATA_W  write data for b.
- b_q0  in  DATA_W  read data from b (mode 1).
- ap_return  out  ACC_W  result register.

Behaviour:
- Reset (ap_rst_n=0 at a rising edge):
  - State goes to IDLE.
  - Index, accumulator, latched n/mode and the read-valid pipeline are cleared.
  - ap_return=0, ap_done=0, ap_ready=0.
  - All ce0/we0 outputs are 0, addresses and b_d0 are 0.
  - ap_idle=1.
  - Reset mid-operation aborts the run with no further SRAM accesses and no done pulse.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - ap_idle=1.
  - If ap_start=1: latch n and mode, clear the accumulator and index i.
  - Go to DONE if n==0, else to RUN.
- RUN:
  - Each cycle, issue element i: a_ce0=1, a_address0=i.
  - Mode 1 only: also b_ce0=1, b_address0=i.
  - Increment i. After issuing i=n-1, go to DRAIN.
  - One issue per cycle; no stalls.
- Read-valid pipeline:
  - A shift register of depth RD_LAT carries {valid, index}.
  - In the cycle where valid emerges, q0 is consumed:
    - mode 0: acc += sext(a_q0).
    - mode 1: acc += sext(a_q0) * sext(b_q0). The product is formed at 2*DATA_W and then truncated or sign-extended to ACC_W.
    - mode 2: acc += sext(a_q0), and in the same cycle b_ce0=1, b_we0=1, b_address0=index, b_d0 = low DATA_W bits of (acc + sext(a_q0)).
  - All arithmetic wraps modulo 2^ACC_W. There is no saturation.
- DRAIN:
  - No new issues.
  - Stay in DRAIN until the pipeline is empty, i.e. the last element has been consumed; then go to DONE.
- DONE:
  - Lasts exactly one cycle, with ap_done=1 and ap_ready=1.
  - ap_return is loaded with the final acc at the edge entering DONE and held until the next start's DONE.
  - Then go to IDLE. If ap_start is still 1, a new run is accepted in the following IDLE cycle.
- Latency: with start sampled in cycle 0, ap_done is high in cycle n+RD_LAT+1. For n=0, ap_done is high in cycle 1.
- Port conflict: mode 2 reads only a and writes only b, so there is no port conflict.
- In-place aliasing of a and b is not supported.
- ap_start toggling during RUN, DRAIN or DONE is ignored.

Test Plan:
- RD_LAT=1, a[0..9]=1..10, n=10, mode 0:
  - ap_return=55.
  - ap_done in cycle 12, exactly 1 cycle wide.
  - a_ce0 high for exactly 10 cycles.
- mode 1, a=1..10, b all 2, n=10:
  - ap_return=110.
  - b_we0 never asserted.
- mode 2, a=1..10, n=10:
  - b[0..9] = 1,3,6,10,15,21,28,36,45,55.
  - ap_return=55.
  - a[] unchanged.
- n=0, mode 0:
  - ap_done in cycle 1, ap_return=0.
  - No ce0 activity.
- Signed/wrap, ACC_W=32: a={-3,5} gives 2; a={0x7FFFFFFF,0x7FFFFFFF} gives 0xFFFFFFFE.
- Reset and back-to-back:
  - ap_rst_n=0 in cycle 5 of an n=10 run: next cycle ap_idle=1, ce0=0, no done pulse; a rerun then returns 55.
  - Repeat with RD_LAT=3: done in cycle 14, same results.
  - ap_start held high: two consecutive runs, each with its own done pulse.
